// File: rtl/result_drain_if.sv
// Handshake bundle for result_drain: upstream FIFO pop port and the block
// result ready/valid port.
interface result_drain_if #(
   parameter int DATA_W = 16,
   parameter int SUM_W  = 32
);
   logic              fifo_empty;
   logic              fifo_read;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_valid;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [SUM_W-1:0]  out_sum;
   logic [7:0]        out_cnt;
   logic [DATA_W-1:0] out_max;
   logic              busy;

   modport master (
      output fifo_empty, fifo_dout, fifo_valid, flush, out_ready,
      input  fifo_read, out_valid, out_sum, out_cnt, out_max, busy
   );

   modport slave (
      input  fifo_empty, fifo_dout, fifo_valid, flush, out_ready,
      output fifo_read, out_valid, out_sum, out_cnt, out_max, busy
   );
endinterface

// File: rtl/result_drain.sv
// Pops words from the upstream FIFO, accumulates them into blocks of BLOCK_LEN
// and presents sum/count(/max) on a ready/valid port. Max tracking is built
// only when RESULT_DRAIN_MAX_EN is defined; otherwise out_max is tied to 0.
module result_drain #(
   parameter int BLOCK_LEN = 8,
   parameter int DATA_W    = 16,
   parameter int SUM_W     = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   result_drain_if.slave  bus
);
   localparam logic [7:0] LEN = 8'(BLOCK_LEN);

   typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, OUT = 2'd2} state_e;

   state_e           state_q;
   logic [SUM_W-1:0] acc_q;
   logic [7:0]       cnt_q;
   logic             flag_q;
   logic             read_q;

   logic             flush_pend;
   logic [7:0]       cnt_d;
   logic [SUM_W-1:0] acc_d;

   // A flush arriving in the same cycle counts as already pending.
   assign flush_pend = flag_q | bus.flush;
   assign cnt_d      = cnt_q + 8'd1;
   assign acc_d      = acc_q + SUM_W'(bus.fifo_dout);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         acc_q   <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         read_q  <= 1'b0;
      end else begin
         read_q <= 1'b0;
         case (state_q)
            FETCH: begin
               if (!bus.fifo_empty) begin
                  read_q  <= 1'b1;
                  flag_q  <= flush_pend;
                  state_q <= WAIT;
               end else if (flush_pend && cnt_q != 8'd0) begin
                  flag_q  <= 1'b1;
                  state_q <= OUT;
               end else begin
                  flag_q  <= 1'b0;
               end
            end
            WAIT: begin
               flag_q <= flush_pend;
               if (bus.fifo_valid) begin
                  acc_q   <= acc_d;
                  cnt_q   <= cnt_d;
                  state_q <= (cnt_d == LEN || flush_pend) ? OUT : FETCH;
               end
            end
            OUT: begin
               // Flushes are ignored here; the flag is cleared with the block.
               if (bus.out_ready) begin
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  flag_q  <= 1'b0;
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

`ifdef RESULT_DRAIN_MAX_EN
   logic [DATA_W-1:0] max_q;
   logic              take;
   logic              drain;

   assign take  = (state_q == WAIT) && bus.fifo_valid;
   assign drain = (state_q == OUT) && bus.out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         max_q <= '0;
      else if (drain)
         max_q <= '0;
      else if (take && bus.fifo_dout > max_q)
         max_q <= bus.fifo_dout;
   end

   assign bus.out_max = max_q;
`else
   assign bus.out_max = '0;
`endif

   assign bus.fifo_read = read_q;
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_sum   = acc_q;
   assign bus.out_cnt   = cnt_q;
   assign bus.busy      = (cnt_q != 8'd0) || (state_q == OUT);
endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: queue-based FIFO model, protocol monitor
// and block-level reference sums/maxima computed from the pushed word lists.
module tb_result_drain;
   localparam int BL = 4;
`ifdef RESULT_DRAIN_MAX_EN
   localparam bit MAX_ON = 1'b1;
`else
   localparam bit MAX_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] sum;
      logic [7:0]  cnt;
      logic [15:0] mx;
   } res_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   result_drain_if #(.DATA_W(16), .SUM_W(32)) a ();
   result_drain_if #(.DATA_W(16), .SUM_W(16)) b ();

   result_drain #(.BLOCK_LEN(BL), .DATA_W(16), .SUM_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .bus(a.slave));
   result_drain #(.BLOCK_LEN(2), .DATA_W(16), .SUM_W(16)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(b.slave));

   int errors = 0;
   int checks = 0;
   logic [15:0] fq[$];
   res_t res_q[$];
   int rd_cnt = 0;
   int rd_viol = 0;
   int stab_viol = 0;

   assign a.fifo_empty = (fq.size() == 0);

   function automatic logic [15:0] em(input logic [15:0] v);
      return MAX_ON ? v : 16'd0;
   endfunction

   // FIFO model: registered pop, dout/valid one cycle after read.
   initial begin : fifo_model
      logic rd;
      a.fifo_valid = 1'b0;
      a.fifo_dout  = '0;
      forever begin
         @(posedge clk);
         rd = a.fifo_read;
         #1;
         if (rd && fq.size() > 0) begin
            a.fifo_dout  = fq.pop_front();
            a.fifo_valid = 1'b1;
         end else begin
            a.fifo_valid = 1'b0;
         end
      end
   end

   // Protocol monitor: read pulse shape, stall stability, accepted results.
   initial begin : monitor
      logic prd, pv, pr;
      logic [31:0] ps;
      logic [7:0]  pc;
      logic [15:0] pm;
      res_t r;
      prd = 1'b0; pv = 1'b0; pr = 1'b0; ps = '0; pc = '0; pm = '0;
      forever begin
         @(negedge clk);
         if (a.fifo_read === 1'b1) begin
            rd_cnt++;
            if (prd || a.out_valid) rd_viol++;
         end
         if (pv && !pr && reset_n)
            if (!a.out_valid || a.out_sum !== ps || a.out_cnt !== pc || a.out_max !== pm)
               stab_viol++;
         if (a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
            r.sum = a.out_sum; r.cnt = a.out_cnt; r.mx = a.out_max;
            res_q.push_back(r);
         end
         prd = a.fifo_read; pv = a.out_valid; pr = a.out_ready;
         ps = a.out_sum; pc = a.out_cnt; pm = a.out_max;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_rd(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (rd_cnt >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_res(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step(1);
         if (res_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      a.flush = 1'b0; a.out_ready = 1'b0;
      b.fifo_empty = 1'b1; b.fifo_dout = '0; b.fifo_valid = 1'b0;
      b.flush = 1'b0; b.out_ready = 1'b1;
      step(3);
      checks++;
      if ({a.fifo_read, a.out_valid, a.busy} !== 3'b000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 000", {a.fifo_read, a.out_valid, a.busy});
      end
      checks++;
      if (a.out_sum !== 32'd0 || a.out_cnt !== 8'd0 || a.out_max !== 16'd0) begin
         errors++; $display("FAIL reset_data: got sum=%0d cnt=%0d max=%0d want 0", a.out_sum, a.out_cnt, a.out_max);
      end
      @(negedge clk);
      reset_n = 1'b1;
      step(2);
      checks++;
      if (a.out_valid !== 1'b0 || a.busy !== 1'b0) begin
         errors++; $display("FAIL reset_release: got valid=%b busy=%b want 0", a.out_valid, a.busy);
      end
   endtask

   task automatic test_empty();
      int base;
      int bad;
      base = rd_cnt;
      bad = 0;
      a.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (a.fifo_read !== 1'b0 || a.busy !== 1'b0 || a.out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || rd_cnt != base) begin
         errors++; $display("FAIL empty_idle: got %0d bad cycles, %0d reads want 0", bad, rd_cnt - base);
      end
   endtask

   task automatic test_basic();
      int base;
      bit ok;
      res_t r;
      base = rd_cnt;
      fq.push_back(16'd4); fq.push_back(16'd9); fq.push_back(16'd16); fq.push_back(16'd25);
      wait_res(1, ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL basic_timeout: got no result want 1");
         return;
      end
      r = res_q.pop_front();
      checks++;
      if (r.sum !== 32'd54 || r.cnt !== 8'd4 || r.mx !== em(16'd25)) begin
         errors++; $display("FAIL basic_result: got sum=%0d cnt=%0d max=%0d want 54/4/%0d", r.sum, r.cnt, r.mx, em(16'd25));
      end
      step(3);
      checks++;
      if (rd_cnt - base != 4 || rd_viol != 0) begin
         errors++; $display("FAIL basic_reads: got %0d reads, %0d violations want 4, 0", rd_cnt - base, rd_viol);
      end
   endtask

   task automatic test_flush();
      int base;
      bit ok;
      res_t r;
      base = rd_cnt;
      a.out_ready = 1'b0;
      fq.push_back(16'd36); fq.push_back(16'd49); fq.push_back(16'd7);
      wait_rd(base + 2, ok);
      a.flush = 1'b1;
      step(1);
      a.flush = 1'b0;
      step(10);
      checks++;
      if (!ok || a.out_valid !== 1'b1 || a.out_sum !== 32'd85 || a.out_cnt !== 8'd2) begin
         errors++; $display("FAIL flush_block: got valid=%b sum=%0d cnt=%0d want 1/85/2", a.out_valid, a.out_sum, a.out_cnt);
      end
      checks++;
      if (rd_cnt - base != 2) begin
         errors++; $display("FAIL flush_hold: got %0d reads want 2", rd_cnt - base);
      end
      a.out_ready = 1'b1;
      wait_res(1, ok);
      r = ok ? res_q.pop_front() : '{32'hx, 8'hx, 16'hx};
      checks++;
      if (r.sum !== 32'd85 || r.cnt !== 8'd2 || r.mx !== em(16'd49)) begin
         errors++; $display("FAIL flush_result: got sum=%0d cnt=%0d max=%0d want 85/2/%0d", r.sum, r.cnt, r.mx, em(16'd49));
      end
      wait_rd(base + 3, ok);
      step(3);
      checks++;
      if (!ok || a.busy !== 1'b1 || a.out_valid !== 1'b0 || a.out_cnt !== 8'd1) begin
         errors++; $display("FAIL flush_partial: got busy=%b valid=%b cnt=%0d want 1/0/1", a.busy, a.out_valid, a.out_cnt);
      end
      a.flush = 1'b1;
      step(1);
      a.flush = 1'b0;
      wait_res(1, ok);
      r = ok ? res_q.pop_front() : '{32'hx, 8'hx, 16'hx};
      checks++;
      if (r.sum !== 32'd7 || r.cnt !== 8'd1 || r.mx !== em(16'd7)) begin
         errors++; $display("FAIL flush_idle: got sum=%0d cnt=%0d max=%0d want 7/1/%0d", r.sum, r.cnt, r.mx, em(16'd7));
      end
      step(2);
      checks++;
      if (a.busy !== 1'b0) begin
         errors++; $display("FAIL flush_busy: got %b want 0", a.busy);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] w[8];
      logic [31:0] es[2];
      logic [15:0] em_[2];
      int base, r0, sv;
      bit ok;
      res_t r;
      base = rd_cnt;
      a.out_ready = 1'b0;
      es[0] = '0; es[1] = '0; em_[0] = '0; em_[1] = '0;
      for (int i = 0; i < 8; i++) begin
         w[i] = 16'($urandom());
         fq.push_back(w[i]);
         es[i/4] += 32'(w[i]);
         if (w[i] > em_[i/4]) em_[i/4] = w[i];
      end
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (a.out_valid === 1'b1) begin ok = 1'b1; break; end
      end
      r0 = rd_cnt;
      sv = stab_viol;
      step(10);
      checks++;
      if (!ok || rd_cnt != r0 || r0 - base != 4) begin
         errors++; $display("FAIL bp_stall_reads: got %0d reads before, %0d during want 4, 0", r0 - base, rd_cnt - r0);
      end
      checks++;
      if (stab_viol != sv || a.out_valid !== 1'b1 || res_q.size() != 0) begin
         errors++; $display("FAIL bp_stable: got %0d changes valid=%b want 0, 1", stab_viol - sv, a.out_valid);
      end
      a.out_ready = 1'b1;
      step(1);
      checks++;
      if (res_q.size() != 1 || a.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_accept: got %0d results valid=%b want 1, 0", res_q.size(), a.out_valid);
      end
      wait_res(2, ok);
      for (int k = 0; k < 2; k++) begin
         r = (res_q.size() > 0) ? res_q.pop_front() : '{32'hx, 8'hx, 16'hx};
         checks++;
         if (r.sum !== es[k] || r.cnt !== 8'd4 || r.mx !== em(em_[k])) begin
            errors++; $display("FAIL bp_block%0d: got sum=%0d cnt=%0d max=%0d want %0d/4/%0d", k, r.sum, r.cnt, r.mx, es[k], em(em_[k]));
         end
      end
   endtask

   task automatic b_pop(input logic [15:0] v, output bit ok);
      ok = 1'b0;
      b.fifo_empty = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (b.fifo_read === 1'b1) begin ok = 1'b1; break; end
      end
      b.fifo_empty = 1'b1;
      step(1);
      b.fifo_dout = v;
      b.fifo_valid = 1'b1;
      step(1);
      b.fifo_valid = 1'b0;
   endtask

   task automatic test_wrap();
      bit ok1, ok2;
      b_pop(16'hFFFF, ok1);
      b_pop(16'h0003, ok2);
      checks++;
      if (!ok1 || !ok2 || b.out_valid !== 1'b1 || b.out_sum !== 16'h0002 || b.out_cnt !== 8'd2) begin
         errors++; $display("FAIL wrap_sum: got valid=%b sum=%h cnt=%0d want 1/0002/2", b.out_valid, b.out_sum, b.out_cnt);
      end
      checks++;
      if (b.out_max !== em(16'hFFFF)) begin
         errors++; $display("FAIL wrap_max: got %h want %h", b.out_max, em(16'hFFFF));
      end
      step(2);
      checks++;
      if (b.out_valid !== 1'b0 || b.busy !== 1'b0) begin
         errors++; $display("FAIL wrap_drain: got valid=%b busy=%b want 0", b.out_valid, b.busy);
      end
   endtask

   task automatic test_reset_midblock();
      int base;
      bit ok;
      res_t r;
      base = rd_cnt;
      a.out_ready = 1'b1;
      fq.push_back(16'd1000); fq.push_back(16'd2000); fq.push_back(16'd3000); fq.push_back(16'd4000);
      wait_rd(base + 4, ok);
      checks++;
      if (!ok || a.busy !== 1'b1 || a.out_cnt !== 8'd3) begin
         errors++; $display("FAIL rst_pre: got busy=%b cnt=%0d want 1/3", a.busy, a.out_cnt);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({a.fifo_read, a.out_valid, a.busy} !== 3'b000 || a.out_sum !== 32'd0 || a.out_cnt !== 8'd0 || a.out_max !== 16'd0) begin
         errors++; $display("FAIL rst_mid: got rd=%b v=%b busy=%b sum=%0d cnt=%0d want all 0", a.fifo_read, a.out_valid, a.busy, a.out_sum, a.out_cnt);
      end
      #1;
      reset_n = 1'b1;
      step(3);
      checks++;
      if (a.busy !== 1'b0 || a.out_valid !== 1'b0 || res_q.size() != 0) begin
         errors++; $display("FAIL rst_after: got busy=%b valid=%b results=%0d want 0", a.busy, a.out_valid, res_q.size());
      end
      fq.push_back(16'd64); fq.push_back(16'd81); fq.push_back(16'd100); fq.push_back(16'd121);
      wait_res(1, ok);
      r = ok ? res_q.pop_front() : '{32'hx, 8'hx, 16'hx};
      checks++;
      if (r.sum !== 32'd366 || r.cnt !== 8'd4 || r.mx !== em(16'd121)) begin
         errors++; $display("FAIL rst_block: got sum=%0d cnt=%0d max=%0d want 366/4/%0d", r.sum, r.cnt, r.mx, em(16'd121));
      end
   endtask

   task automatic test_random();
      localparam int N = 40;
      logic [15:0] w[N];
      int idx;
      int nres;
      logic [31:0] es;
      logic [15:0] ex;
      res_t r;
      idx = 0;
      for (int i = 0; i < N; i++) w[i] = 16'($urandom());
      for (int c = 0; c < 4000; c++) begin
         step(1);
         a.out_ready = ($urandom_range(0, 3) != 0);
         if (idx < N && $urandom_range(0, 2) == 0) begin
            fq.push_back(w[idx]);
            idx++;
         end
         if (idx == N && res_q.size() >= N / BL) break;
      end
      a.out_ready = 1'b1;
      nres = res_q.size();
      checks++;
      if (nres != N / BL) begin
         errors++; $display("FAIL rand_count: got %0d results want %0d", nres, N / BL);
      end
      for (int k = 0; k < N / BL && res_q.size() > 0; k++) begin
         es = '0; ex = '0;
         for (int j = 0; j < BL; j++) begin
            es += 32'(w[k*BL + j]);
            if (w[k*BL + j] > ex) ex = w[k*BL + j];
         end
         r = res_q.pop_front();
         checks++;
         if (r.sum !== es || r.cnt !== 8'(BL) || r.mx !== em(ex)) begin
            errors++; $display("FAIL rand_block%0d: got sum=%0d cnt=%0d max=%0d want %0d/%0d/%0d", k, r.sum, r.cnt, r.mx, es, BL, em(ex));
         end
      end
      checks++;
      if (rd_viol != 0 || stab_viol != 0) begin
         errors++; $display("FAIL protocol: got read_viol=%0d stable_viol=%0d want 0", rd_viol, stab_viol);
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_basic();
      test_flush();
      test_backpressure();
      test_wrap();
      test_reset_midblock();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
